// File: rtl/qsys_pwm_pkg.sv
// Shared constants for the Qsys PWM device: register offsets, bit indices, datapath width.
package qsys_pwm_pkg;
  localparam int PWM_W = 16;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_DUTY     = 3'd3;
  localparam logic [2:0] REG_COUNT    = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_POL    = 1;
  localparam int STATUS_WRAP = 0;

  // Byte-lane merge of a write into an existing register value.
  function automatic logic [PWM_W-1:0] lane_merge(input logic [PWM_W-1:0] old_v,
                                                  input logic [PWM_W-1:0] new_v,
                                                  input logic [1:0]       be);
    logic [PWM_W-1:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    return (old_v & ~m) | (new_v & m);
  endfunction
endpackage

// File: rtl/qsys_pwm_core.sv
// PWM engine: prescaler, period counter, shadow/active period and duty, registered outputs.
module qsys_pwm_core
  import qsys_pwm_pkg::*;
#(
  parameter logic [PWM_W-1:0] RESET_PERIOD = 16'hFFFF
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             en,
  input  logic             pol,
  input  logic [PWM_W-1:0] prescale,
  input  logic [PWM_W-1:0] period_sh,
  input  logic [PWM_W-1:0] duty_sh,
  output logic [PWM_W-1:0] count,
  output logic             wrap_evt,
  output logic             pwm_out,
  output logic             pwm_wrap
);
  logic [PWM_W-1:0] presc, period_act, duty_act;
  logic             tick;

  // >= keeps the prescaler from running the full 16-bit range if PRESCALE shrinks mid-count
  assign tick     = en & (presc >= prescale);
  assign wrap_evt = tick & (count == period_act);

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      presc      <= '0;
      count      <= '0;
      period_act <= RESET_PERIOD;
      duty_act   <= '0;
      pwm_out    <= 1'b0;
      pwm_wrap   <= 1'b0;
    end else begin
      if (!en) begin
        presc      <= '0;
        count      <= '0;
        pwm_wrap   <= 1'b0;
        period_act <= period_sh;
        duty_act   <= duty_sh;
      end else begin
        pwm_wrap <= wrap_evt;
        presc    <= tick ? '0 : presc + 1'b1;
        if (wrap_evt) begin
          count      <= '0;
          period_act <= period_sh;
          duty_act   <= duty_sh;
        end else if (tick) begin
          count <= count + 1'b1;
        end
      end
      pwm_out <= en ? ((count < duty_act) ^ pol) : pol;
    end
  end
endmodule

// File: rtl/qsys_pwm_device.sv
// Register-mapped 16-bit PWM on the Qsys device-side bus; zero-wait writes, one-wait-state reads.
module qsys_pwm_device
  import qsys_pwm_pkg::*;
#(
  parameter int               address_size = 5,
  parameter logic [PWM_W-1:0] RESET_PERIOD = 16'hFFFF
) (
  input  logic                  csi_MCLK_clk,
  input  logic                  rsi_MRST_reset,
  input  logic [address_size:0] device_address,
  input  logic [PWM_W-1:0]      device_writedata,
  input  logic [1:0]            device_byteenable,
  input  logic                  device_write,
  input  logic                  device_read,
  output logic [PWM_W-1:0]      device_readdata,
  output logic                  device_waitrequest,
  output logic                  pwm_out,
  output logic                  pwm_wrap
);
  logic [1:0]       ctrl;
  logic [PWM_W-1:0] prescale, period_sh, duty_sh, count, rd_mux;
  logic             wrap_sts, wrap_evt, rd_phase, in_map, wr_en, rd_start;
  logic [2:0]       reg_sel;

  assign in_map   = ~|device_address[address_size:3];
  assign reg_sel  = device_address[2:0];
  assign wr_en    = device_write & in_map;
  assign rd_start = device_read & ~rd_phase;
  // Reset gating drops the stall at once even while a read is still asserted
  assign device_waitrequest = rd_start & ~rsi_MRST_reset;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      ctrl      <= '0;
      prescale  <= '0;
      period_sh <= RESET_PERIOD;
      duty_sh   <= '0;
      wrap_sts  <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          REG_CTRL:     if (device_byteenable[0]) ctrl <= device_writedata[1:0];
          REG_PRESCALE: prescale  <= lane_merge(prescale, device_writedata, device_byteenable);
          REG_PERIOD:   period_sh <= lane_merge(period_sh, device_writedata, device_byteenable);
          REG_DUTY:     duty_sh   <= lane_merge(duty_sh, device_writedata, device_byteenable);
          default: ;
        endcase
      end
      // A wrap in the same cycle as a clear keeps the flag set
      if (wrap_evt)
        wrap_sts <= 1'b1;
      else if (wr_en && reg_sel == REG_STATUS && device_byteenable[0] &&
               device_writedata[STATUS_WRAP])
        wrap_sts <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (in_map) begin
      case (reg_sel)
        REG_CTRL:     rd_mux = {{(PWM_W-2){1'b0}}, ctrl};
        REG_PRESCALE: rd_mux = prescale;
        REG_PERIOD:   rd_mux = period_sh;
        REG_DUTY:     rd_mux = duty_sh;
        REG_COUNT:    rd_mux = count;
        REG_STATUS:   rd_mux = {{(PWM_W-1){1'b0}}, wrap_sts};
        default:      rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      rd_phase        <= 1'b0;
      device_readdata <= '0;
    end else begin
      rd_phase <= rd_start;
      if (rd_start) device_readdata <= rd_mux;
    end
  end

  qsys_pwm_core #(.RESET_PERIOD(RESET_PERIOD)) u_core (
    .gclk      (csi_MCLK_clk),
    .grst      (rsi_MRST_reset),
    .en        (ctrl[CTRL_EN]),
    .pol       (ctrl[CTRL_POL]),
    .prescale  (prescale),
    .period_sh (period_sh),
    .duty_sh   (duty_sh),
    .count     (count),
    .wrap_evt  (wrap_evt),
    .pwm_out   (pwm_out),
    .pwm_wrap  (pwm_wrap)
  );
endmodule

// File: tb/tb_qsys_pwm_device.sv
// Self-checking bench for qsys_pwm_device: bus reads go through an expected-value queue.
module tb_qsys_pwm_device;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  device_address = '0;
  logic [15:0] device_writedata = '0;
  logic [1:0]  device_byteenable = '0;
  logic        device_write = 1'b0;
  logic        device_read = 1'b0;
  logic [15:0] device_readdata;
  logic        device_waitrequest, pwm_out, pwm_wrap;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  qsys_pwm_device dut (
    .csi_MCLK_clk       (clk),
    .rsi_MRST_reset     (rst),
    .device_address     (device_address),
    .device_writedata   (device_writedata),
    .device_byteenable  (device_byteenable),
    .device_write       (device_write),
    .device_read        (device_read),
    .device_readdata    (device_readdata),
    .device_waitrequest (device_waitrequest),
    .pwm_out            (pwm_out),
    .pwm_wrap           (pwm_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge.
  task automatic bus_write(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
    device_address = a; device_writedata = d; device_byteenable = be; device_write = 1'b1;
    @(negedge clk);
    device_write = 1'b0; device_byteenable = 2'b00;
  endtask

  task automatic bus_read(input string tag, input logic [5:0] a, input logic [15:0] e);
    int wc;
    logic [15:0] exp_v;
    device_address = a; device_read = 1'b1;
    exp_q.push_back(e);
    wc = 0;
    #1;
    if (!device_waitrequest) @(negedge clk);
    while (device_waitrequest && wc < 4) begin
      wc++;
      @(negedge clk);
    end
    chk({tag, "_wait"}, wc, 1);
    exp_v = exp_q.pop_front();
    chk(tag, device_readdata, exp_v);
    device_read = 1'b0;
  endtask

  task automatic sync_wrap(input string tag);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!pwm_wrap && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    if (cnt >= 64) chk({tag, "_wrap_timeout"}, 0, 1);
  endtask

  task automatic measure(input int n, output int hi, output int wr);
    hi = 0; wr = 0;
    for (int i = 0; i < n; i++) begin
      hi += int'(pwm_out);
      wr += int'(pwm_wrap);
      @(negedge clk);
    end
  endtask

  task automatic configure(input logic [15:0] ps, input logic [15:0] per,
                           input logic [15:0] dut_v, input logic [15:0] ctl);
    bus_write(6'd0, 16'h0000, 2'b11);
    bus_write(6'd1, ps, 2'b11);
    bus_write(6'd2, per, 2'b11);
    bus_write(6'd3, dut_v, 2'b11);
    bus_write(6'd0, ctl, 2'b11);
  endtask

  initial begin
    int hi, wr;
    logic [15:0] rst_exp [6];
    rst_exp = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};

    repeat (3) @(negedge clk);
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_pwm_wrap", pwm_wrap, 0);
    chk("rst_waitreq", device_waitrequest, 0);
    chk("rst_readdata", device_readdata, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) bus_read($sformatf("rst_reg%0d", i), 6'(i), rst_exp[i]);
    bus_read("unmapped_reg6", 6'd6, 16'h0000);

    // Byte lanes on PERIOD
    bus_write(6'd2, 16'hABCD, 2'b01);
    bus_read("be01_period", 6'd2, 16'hFFCD);
    bus_write(6'd2, 16'h0000, 2'b00);
    bus_read("be00_period", 6'd2, 16'hFFCD);
    bus_write(6'd2, 16'h1234, 2'b10);
    bus_read("be10_period", 6'd2, 16'h12CD);
    bus_write(6'd4, 16'h5555, 2'b11);
    bus_read("count_ro", 6'd4, 16'h0000);

    // Basic PWM
    configure(16'd0, 16'd9, 16'd3, 16'd1);
    sync_wrap("basic");
    measure(10, hi, wr);
    chk("basic_high", hi, 3);
    chk("basic_wrap", wr, 1);

    bus_write(6'd0, 16'd3, 2'b01);
    sync_wrap("pol");
    measure(10, hi, wr);
    chk("pol_high", hi, 7);

    // Shadowed duty update mid-period
    bus_write(6'd0, 16'd1, 2'b01);
    sync_wrap("shadow");
    bus_write(6'd3, 16'd5, 2'b11);
    measure(10, hi, wr);
    chk("shadow_old_high", hi, 3);
    chk("shadow_old_wrap", wr, 1);
    measure(10, hi, wr);
    chk("shadow_new_high", hi, 5);

    // Sticky WRAP and write-1-to-clear
    bus_read("status_set", 6'd5, 16'h0001);
    sync_wrap("w1c");
    bus_write(6'd5, 16'h0001, 2'b01);
    bus_read("status_cleared", 6'd5, 16'h0000);
    sync_wrap("w1c_race");
    repeat (9) @(negedge clk);
    bus_write(6'd5, 16'h0001, 2'b01);
    bus_read("status_set_wins", 6'd5, 16'h0001);

    // Prescale: 3-cycle tick, 2 counts -> 6-cycle period, high 3
    configure(16'd2, 16'd1, 16'd1, 16'd1);
    sync_wrap("presc");
    measure(6, hi, wr);
    chk("presc_high", hi, 3);
    chk("presc_wrap", wr, 1);
    measure(12, hi, wr);
    chk("presc_wrap_12", wr, 2);

    // Edge duties
    configure(16'd0, 16'd9, 16'd0, 16'd1);
    sync_wrap("duty0");
    measure(10, hi, wr);
    chk("duty0_high", hi, 0);
    chk("duty0_wrap", wr, 1);
    bus_write(6'd3, 16'd20, 2'b11);
    sync_wrap("duty20");
    @(negedge clk);
    measure(10, hi, wr);
    chk("duty20_high", hi, 10);

    // Disable mid-period with POL=1
    sync_wrap("en_off");
    repeat (4) @(negedge clk);
    bus_write(6'd0, 16'd2, 2'b01);
    @(negedge clk);
    bus_read("en_off_count", 6'd4, 16'h0000);
    chk("en_off_pwm_out", pwm_out, 1);
    measure(12, hi, wr);
    chk("en_off_high", hi, 12);
    chk("en_off_wrap", wr, 0);

    // Reset during the wait state of a read
    device_address = 6'd2; device_read = 1'b1;
    #1;
    chk("midread_wait_before", device_waitrequest, 1);
    rst = 1'b1;
    #1;
    chk("midread_wait_in_rst", device_waitrequest, 0);
    @(negedge clk);
    device_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_read("post_rst_period", 6'd2, 16'hFFFF);
    bus_read("post_rst_ctrl", 6'd0, 16'h0000);
    chk("post_rst_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/qsys_pwm_device.md
Name: qsys_pwm_device

Overview:
- 16-bit register-mapped PWM generator on the Qsys device-side bus; sits directly downstream of the 32-to-16 Avalon bridge.
- Its device_* ports connect one-to-one to the bridge's device_* outputs and inputs.
- Provides prescaled counter, shadowed period/duty update at wrap, sticky wrap status and a one-wait-state registered read path.

Parameters:
- address_size, 5, device_address is [address_size:0]. Only offsets 0-5 are decoded; others read 0 and ignore writes.
- RESET_PERIOD, 16'hFFFF, reset value of PERIOD and its shadow.

Ports:
- csi_MCLK_clk  in  1  single clock
- rsi_MRST_reset  in  1  asynchronous, active-high reset
- device_address  in  address_size+1  register offset
- device_writedata  in  16  write data
- device_byteenable  in  2  [0]=bits 7:0, [1]=bits 15:8
- device_write  in  1  write strobe
- device_read  in  1  read strobe
- device_readdata  out  16  read data
- device_waitrequest  out  1  stall
- pwm_out  out  1  PWM output
- pwm_wrap  out  1  one-cycle pulse at period wrap

Behaviour:
- Clocking and reset: one clock, csi_MCLK_clk. Reset rsi_MRST_reset is asynchronous and active-high.
- Register map:
  - 0 CTRL: [0]=EN, [1]=POL, rest 0
  - 1 PRESCALE
  - 2 PERIOD
  - 3 DUTY
  - 4 COUNT (RO)
  - 5 STATUS: [0]=WRAP sticky, write-1-to-clear
- Reset values:
  - CTRL=0, PRESCALE=0, PERIOD and shadow=RESET_PERIOD, DUTY and shadow=0.
  - count=0, prescaler=0, WRAP=0.
  - device_readdata=0, device_waitrequest=0, pwm_out=0, pwm_wrap=0.
- Writes: zero wait states, taken on the clock edge with device_write=1.
  - Each byte lane is written only if its byteenable bit is set; byteenable=00 means no effect.
  - Writes to COUNT have no effect.
- Reads: one wait state.
  - Cycle 1 of device_read: waitrequest=1 (combinational: read & ~rd_phase); readdata is registered from the addressed register.
  - Cycle 2: waitrequest=0 and readdata valid; rd_phase clears.
  - Back-to-back reads each take 2 cycles. A read and write asserted together: the write executes, the read follows its normal timing.
- Prescaler:
  - When EN=1, it counts 0..PRESCALE. tick=1 when prescaler==PRESCALE, then it reloads 0.
  - PRESCALE=0 gives a tick every cycle.
- Counter, on tick:
  - If count==period_act: count<=0, pwm_wrap<=1 (one cycle), WRAP<=1, and period_act/duty_act load from shadows.
  - Otherwise count<=count+1.
  - 16-bit unsigned arithmetic; no overflow is possible because the counter wraps at period_act.
- Shadowing:
  - PERIOD/DUTY writes update the shadow. The active copy updates at wrap.
  - When EN=0, the active copy follows the shadow every cycle.
- Output:
  - active = EN & (count < duty_act).
  - pwm_out is registered: active XOR POL when EN=1, POL when EN=0.
  - DUTY=0 gives never active; DUTY>PERIOD gives always active; PERIOD=0 gives wrap every tick.
- EN 1->0: count and prescaler clear to 0 on the next cycle; pwm_wrap=0.
- STATUS write-1 clear in the same cycle as a wrap: set wins, WRAP stays 1.
- Reset mid-read: waitrequest and rd_phase drop immediately (asynchronous); the read is abandoned.

Decomposition:
- Shared package qsys_pwm_pkg: register offsets (REG_CTRL..REG_STATUS), CTRL bit indices (CTRL_EN, CTRL_POL), STATUS_WRAP index, width constant 16.
- One natural sub-module, qsys_pwm_core: prescaler, counter, shadow/active registers, compare, pwm_out/pwm_wrap.
- The top level holds the register file, byte-lane writes and the read wait-state logic.

Test Plan:
- Reset: after reset, read each of offsets 0-5. Expect 0, 0, FFFF, 0, 0, 0; waitrequest=1 exactly 1 cycle per read.
- Basic PWM: PRESCALE=0, PERIOD=9, DUTY=3, CTRL=1. Expect pwm_out high 3 of every 10 cycles and pwm_wrap every 10 cycles. With POL=1 (CTRL=3), expect high 7 of every 10.
- Shadow timing: while running with PERIOD=9, write DUTY=5 mid-period. Expect duty 3 until the next wrap, then 5.
- Prescale: PRESCALE=2, PERIOD=1, DUTY=1. Expect a 6-cycle period, high for 3 cycles.
- Byte lanes: write 16'hABCD with byteenable=01 to PERIOD (FFFF). Expect a readback of FFCD.
- STATUS: let a wrap occur, read STATUS=1, write 1 to clear, read 0. Issue the clear in the same cycle as a wrap and expect STATUS=1.
- Edge values: DUTY=0 gives pwm_out constantly 0. DUTY=20 with PERIOD=9 gives constantly 1. Clear EN mid-period and expect COUNT to read 0 and pwm_out=POL.
